// File: rtl/serializer_pkg.sv
// Shared types and default sizes for the serializer controller.
package serializer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter that walks the serial bit index towards zero.
module bit_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] r_count;

  // A load wins over a decrement so back-to-back frames start cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && !zero) begin
      r_count <= r_count - ONE;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/serializer_ctrl.sv
// Parallel-to-serial frame controller: sends bits word_len..0 of an accepted
// word, one bit per tick, with frame markers and gapless back-to-back frames.
module serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  word_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              tick,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_idx
);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_word_len;
  logic              r_first;
  logic              w_accept;
  logic              w_zero;

  bit_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .load_val (word_len),
    .dec      (ser_valid & ~w_zero),
    .count    (bit_idx),
    .zero     (w_zero)
  );

  assign w_accept = in_valid & in_ready;

  // Outputs are forced low while reset is asserted, even mid-frame.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    ser_valid    = 1'b0;
    ser_out      = 1'b0;
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    in_ready     = 1'b0;
    if (!reset) begin
      busy        = (r_state == SHIFT);
      ser_valid   = busy & tick;
      ser_out     = ser_valid & r_data[bit_idx];
      frame_end   = ser_valid & w_zero;
      frame_start = ser_valid & r_first & (bit_idx == r_word_len);
      in_ready    = (r_state == IDLE) | frame_end;
      case (r_state)
        IDLE:    if (in_valid) w_state_next = SHIFT;
        SHIFT:   if (frame_end) w_state_next = in_valid ? SHIFT : IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_word_len <= '0;
      r_first    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_data     <= in_data;
        r_word_len <= word_len;
        r_first    <= 1'b1;
      end else if (ser_valid) begin
        r_first    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/serializer_ctrl.md
SERIALIZER_CTRL -- requirements
Module: serializer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which is the parallel word width and the maximum frame length in bits.
REQ-002 SHALL have parameter CNT_W, default 4, which is the bit-index width and equals $clog2(DATA_W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, DATA_W bits: the parallel word to serialize.
REQ-006 SHALL have port word_len, input, CNT_W bits: frame length minus 1, sampled only at word acceptance.
REQ-007 SHALL have port in_valid, input, 1 bit: the producer offers in_data and word_len.
REQ-008 SHALL have port in_ready, output, 1 bit: the controller can accept a word this cycle.
REQ-009 SHALL have port tick, input, 1 bit: bit-rate enable; one serial bit advances per cycle with tick=1.
REQ-010 SHALL have port ser_out, output, 1 bit: the current serial bit.
REQ-011 SHALL have port ser_valid, output, 1 bit: ser_out is consumed this cycle.
REQ-012 SHALL have port frame_start, output, 1 bit: ser_valid carries the first bit of the frame.
REQ-013 SHALL have port frame_end, output, 1 bit: ser_valid carries the last bit of the frame.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port bit_idx, output, CNT_W bits: the current down-count index.

Function
REQ-016 FSM SHALL have states IDLE and SHIFT.
REQ-017 in_ready SHALL be 1 in IDLE, and in SHIFT when frame_end=1; otherwise 0.
REQ-018 Acceptance SHALL occur when in_valid=1 and in_ready=1: data_reg<=in_data, bit_idx<=word_len, state<=SHIFT.
REQ-019 In SHIFT, ser_out SHALL equal data_reg[bit_idx], so frames are sent MSB-of-frame first, from bit word_len down to bit 0.
REQ-020 ser_valid SHALL equal (state==SHIFT && tick); bit_idx SHALL decrement only on ser_valid.
REQ-021 frame_start SHALL be ser_valid with bit_idx==word_len_reg and no bit yet sent in the frame (tracked by a first-bit flag).
REQ-022 frame_end SHALL be ser_valid with bit_idx==0.
REQ-023 On frame_end without acceptance: state<=IDLE and bit_idx<=0.
REQ-024 On frame_end with acceptance, the next frame SHALL load with no gap: state stays SHIFT and bit_idx<=new word_len.
REQ-025 Latency: a word accepted in cycle T SHALL make its first bit eligible at T+1 (ser_valid at the first tick at or after T+1).
REQ-026 tick=0 in SHIFT SHALL hold bit_idx, data_reg and the first-bit flag unchanged.
REQ-027 word_len=0 SHALL produce a 1-bit frame with frame_start and frame_end asserted together.
REQ-028 in_data and word_len SHALL be ignored when not accepted; bits of data_reg above word_len_reg SHALL be ignored.
REQ-029 busy SHALL equal (state==SHIFT).
REQ-030 ser_out SHALL be 0 whenever ser_valid=0.

Reset
REQ-031 reset=1 SHALL force state=IDLE, bit_idx=0, data_reg=0, word_len_reg=0 and first-bit flag=1.
REQ-032 During reset, outputs SHALL be: in_ready=0, ser_valid=0, ser_out=0, frame_start=0, frame_end=0, busy=0.
REQ-033 Reset mid-frame SHALL abandon the frame with no frame_end, and in_ready SHALL reassert in the first cycle after reset deasserts.
REQ-034 Reset SHALL take priority over acceptance and tick in the same cycle.

Structure
REQ-035 A shared package serializer_pkg SHALL hold the state enum (IDLE, SHIFT) and the DATA_W and CNT_W defaults.
REQ-036 One sub-module, bit_down_counter, SHALL hold the loadable down-counter: inputs load, load_val, dec; output zero flag. All other logic stays in serializer_ctrl.

Verification
REQ-037 Scenario 1: tick=1 constant, accept in_data=16'hA5C3, word_len=7 -> ser_out=1,1,0,0,0,0,1,1 over 8 cycles; frame_start on bit 1, frame_end on bit 8.
REQ-038 Scenario 2: back-to-back words 16'h000F and 16'hF000, word_len=15, in_valid held -> 32 contiguous ser_valid cycles, in_ready pulsing on each frame_end.
REQ-039 Scenario 3: tick every 3rd cycle, word_len=3, in_data=4'b1001 -> 4 ser_valid pulses 3 cycles apart; bit_idx holds between ticks.
REQ-040 Scenario 4: word_len=0, in_data bit0=1 -> single cycle with ser_out=1, frame_start=1 and frame_end=1.
REQ-041 Scenario 5: reset asserted after 5 of 16 bits -> busy=0 and no frame_end; a new word is accepted 1 cycle after reset deasserts.
REQ-042 Scenario 6: in_valid=1 with in_ready=0 mid-frame -> word not taken, current frame unchanged; taken on frame_end.
